// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - register scoreboard tracking pending long-latency writes between decode and EX
module pipeline_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_IDX_W    = 5,
    parameter int NUM_SRC      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0] issue_src,
    input  logic [NUM_SRC-1:0]           issue_src_used,
    input  logic [REG_IDX_W-1:0]         issue_dst,
    input  logic                         issue_dst_we,
    input  logic                         issue_long,
    input  logic                         flush,
    input  logic                         wb_valid,
    input  logic [REG_IDX_W-1:0]         wb_dst,
    output logic                         issue_stall,
    output logic [NUM_REGS-1:0]          pending_vec,
    output logic [CNT_W-1:0]             pending_count,
    output logic                         idle,
    output logic                         wb_spurious
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0] pending_vec_q, pending_vec_d;
    logic [CNT_W-1:0]    pending_count_q, pending_count_d;
    logic                wb_spurious_q, wb_spurious_d;

    logic                wb_live, rel, spurious_hit;
    logic                dst_live, raw, waw, full, acc, set;
    logic [NUM_REGS-1:0] eff;
    logic [REG_IDX_W-1:0] src;
    logic [CNT_W-1:0]    cnt_after_rel;

    assign wb_live      = wb_valid && (wb_dst != '0);
    assign rel          = wb_live && pending_vec_q[wb_dst];
    assign spurious_hit = wb_live && !pending_vec_q[wb_dst];
    assign dst_live     = issue_dst_we && (issue_dst != '0);

    // A register retiring this cycle is already visible through the RF write-through.
    always_comb begin
        eff = pending_vec_q;
        if (rel) begin
            eff[wb_dst] = 1'b0;
        end
    end

    always_comb begin
        raw = 1'b0;
        src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src = issue_src[k*REG_IDX_W +: REG_IDX_W];
            if (issue_src_used[k] && (src != '0) && eff[src]) begin
                raw = 1'b1;
            end
        end
    end

    assign cnt_after_rel = pending_count_q - CNT_W'(rel);
    assign waw           = dst_live && eff[issue_dst];
    assign full          = issue_long && dst_live && (cnt_after_rel == MAX_CNT);
    assign issue_stall   = issue_valid && !flush && (raw || waw || full);
    assign acc           = issue_valid && !flush && !issue_stall;
    assign set           = acc && issue_long && dst_live;

    // Clear first, then set, so a same-register release and re-issue leaves the bit pending.
    always_comb begin
        pending_vec_d = pending_vec_q;
        if (rel) begin
            pending_vec_d[wb_dst] = 1'b0;
        end
        if (set) begin
            pending_vec_d[issue_dst] = 1'b1;
        end
        pending_count_d = pending_count_q + CNT_W'(set) - CNT_W'(rel);
        wb_spurious_d   = wb_spurious_q || spurious_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_vec_q   <= '0;
            pending_count_q <= '0;
            wb_spurious_q   <= 1'b0;
        end else begin
            pending_vec_q   <= pending_vec_d;
            pending_count_q <= pending_count_d;
            wb_spurious_q   <= wb_spurious_d;
        end
    end

    assign pending_vec   = pending_vec_q;
    assign pending_count = pending_count_q;
    assign idle          = (pending_count_q == '0);
    assign wb_spurious   = wb_spurious_q;

    a_count_consistent: assert property (@(posedge clk) disable iff (reset)
        (int'(pending_count_q) == $countones(pending_vec_q)) && !pending_vec_q[0]);

endmodule
